peripheral_gpio_edge_irq_bb: RTL and testbench
==============================================

Name: peripheral_gpio_edge_irq_bb

Overview:
Per-pin input conditioning stage for the BlackBone GPIO. It sits directly downstream of the per-pin two-flop synchronizer cells. It consumes their synchronized outputs and applies a programmable debounce filter. It detects rising and falling edges on the filtered value, holds sticky per-pin interrupt-pending bits with write-1-to-clear, and drives one combined interrupt line to the bus register block.

Parameters:
WIDTH, 8, number of GPIO pins handled.
DEBOUNCE_W, 4, width of the debounce counter and threshold; maximum threshold is 2^DEBOUNCE_W-1.

Ports:
clk  input  1  receiving clock, same domain as the synchronizer cells.
rst  input  1  reset; synchronous, active-low (asserted when 0, sampled on rising clk).
sync_in  input  WIDTH  synchronized pin values from the synchronizer cells.
db_threshold  input  DEBOUNCE_W  required stable cycles minus one; 0 = no debounce.
rise_en  input  WIDTH  per-pin enable: a rising edge sets pending.
fall_en  input  WIDTH  per-pin enable: a falling edge sets pending.
ie  input  WIDTH  per-pin interrupt enable (masks irq only, not pending).
clr  input  WIDTH  one-cycle write-1-to-clear strobe for pending bits.
filt_out  output  WIDTH  debounced pin value.
edge_rise  output  WIDTH  one-cycle pulse when filt_out goes 0->1.
edge_fall  output  WIDTH  one-cycle pulse when filt_out goes 1->0.
pending  output  WIDTH  sticky interrupt-pending bits.
irq  output  1  OR of (pending & ie).

Behaviour:
- Reset (rst==0 at a clk edge): filt_out, edge_rise, edge_fall, pending, all counters = 0. irq = 0 one cycle later at most, because it is derived from registers. Reset takes priority over all other inputs and discards any count in progress.
- Filter, independent per bit i, with registered cnt[i] (DEBOUNCE_W bits):
  - If sync_in[i]==filt_out[i]: cnt<=0.
  - Else if cnt>=db_threshold: filt_out[i]<=sync_in[i], cnt<=0.
  - Else cnt<=cnt+1.
- Filter latency: a level change that stays stable appears on filt_out exactly db_threshold+1 cycles after it appears on sync_in.
- Glitch rejection: a pulse shorter than db_threshold+1 cycles never reaches filt_out, and cnt returns to 0.
- Counter width: cnt never exceeds db_threshold, so it cannot overflow. Lowering db_threshold mid-count commits on the next cycle because the compare is >=.
- Edges: edge_rise[i] and edge_fall[i] are registered. They are asserted in the same cycle in which filt_out[i] shows its new value, and last exactly one cycle. Rise and fall are never both 1 on one bit.
- Pending, per bit:
  - set = (edge_rise_next & rise_en) | (edge_fall_next & fall_en), updated on the same edge as filt_out.
  - If set and clr arrive in the same cycle, set wins and pending stays 1.
  - clr on a bit that is not pending has no effect.
  - Changing rise_en, fall_en or ie never clears pending.
- irq = |(pending & ie), combinational from registers only (no input-to-output path). Enabling ie on an already-pending bit raises irq in the same cycle.
- After reset: filt_out=0. If sync_in is held at 1, filt_out rises after db_threshold+1 cycles and produces a genuine rise event. This is intended.

Decomposition:
- Package peripheral_gpio_bb_pkg holds:
  - the DEBOUNCE_W default;
  - typedef gpio_vec_t (logic [WIDTH-1:0] for the default width);
  - localparam DB_BYPASS = 0.
- Sub-module peripheral_gpio_debounce_bb: a single-bit filter plus edge generator (ports clk, rst, din, threshold, dout, rise, fall). It is instantiated WIDTH times in a generate loop.
- Pending, clear and irq logic stays in the top module.

Test Plan:
- Reset with sync_in=8'hFF, db_threshold=3, rst held low 5 cycles, then released -> filt_out=8'h00 during reset; filt_out=8'hFF and edge_rise=8'hFF exactly 4 cycles after release; edge_rise back to 0 the next cycle.
- db_threshold=0, toggle sync_in[0] 0->1 -> filt_out[0]=1 and edge_rise[0]=1 one cycle later; with rise_en[0]=1 and ie[0]=1, pending=8'h01 and irq=1.
- db_threshold=5, 3-cycle high glitch on sync_in[2] -> filt_out[2] stays 0, no edges, pending unchanged; a 6-cycle-stable high -> filt_out[2]=1 on cycle 6.
- pending[1]=1, pulse clr=8'h02 -> pending[1]=0 and irq=0 next cycle. Then a fall event with fall_en[1]=1 coinciding with clr[1] -> pending[1] remains 1.
- rise_en=0 and fall_en=8'h10; rise then fall on pin 4 -> only the fall sets pending[4]. Then ie=0 gives irq=0 with pending[4]=1; setting ie[4]=1 gives irq=1 in the same cycle.

Source files
------------

// File: rtl/peripheral_gpio_bb_pkg.sv
// Shared types and defaults for the BlackBone GPIO input conditioning stage.
package peripheral_gpio_bb_pkg;

  localparam int GPIO_WIDTH_DEF = 8;
  localparam int DEBOUNCE_W_DEF = 4;
  localparam int DB_BYPASS      = 0;

  typedef logic [GPIO_WIDTH_DEF-1:0] gpio_vec_t;

endpackage

// File: rtl/peripheral_gpio_debounce_bb.sv
// Single-pin debounce filter. rise/fall are the commit strobes for the coming edge,
// so the parent can register edges and pending on the same edge as dout.
module peripheral_gpio_debounce_bb
  import peripheral_gpio_bb_pkg::*;
#(
  parameter int DEBOUNCE_W = DEBOUNCE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din,
  input  logic [DEBOUNCE_W-1:0] threshold,
  output logic                  dout,
  output logic                  rise,
  output logic                  fall
);

  logic                  dout_q, dout_d;
  logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;

  // The >= compare lets a lowered threshold commit a count already past it.
  always_comb begin
    dout_d = dout_q;
    cnt_d  = cnt_q;
    rise   = 1'b0;
    fall   = 1'b0;
    if (din == dout_q) begin
      cnt_d = '0;
    end else if (cnt_q >= threshold) begin
      dout_d = din;
      cnt_d  = '0;
      rise   = din;
      fall   = ~din;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/peripheral_gpio_edge_irq_bb.sv
// Per-pin debounce, edge detection, sticky W1C pending bits and combined irq
// for the BlackBone GPIO.
module peripheral_gpio_edge_irq_bb
  import peripheral_gpio_bb_pkg::*;
#(
  parameter int WIDTH      = GPIO_WIDTH_DEF,
  parameter int DEBOUNCE_W = DEBOUNCE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      sync_in,
  input  logic [DEBOUNCE_W-1:0] db_threshold,
  input  logic [WIDTH-1:0]      rise_en,
  input  logic [WIDTH-1:0]      fall_en,
  input  logic [WIDTH-1:0]      ie,
  input  logic [WIDTH-1:0]      clr,
  output logic [WIDTH-1:0]      filt_out,
  output logic [WIDTH-1:0]      edge_rise,
  output logic [WIDTH-1:0]      edge_fall,
  output logic [WIDTH-1:0]      pending,
  output logic                  irq
);

  logic [WIDTH-1:0] rise_nxt, fall_nxt;
  logic [WIDTH-1:0] edge_rise_q, edge_rise_d;
  logic [WIDTH-1:0] edge_fall_q, edge_fall_d;
  logic [WIDTH-1:0] pending_q, pending_d;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
    peripheral_gpio_debounce_bb #(
      .DEBOUNCE_W(DEBOUNCE_W)
    ) u_db (
      .clk      (clk),
      .rst      (rst),
      .din      (sync_in[gi]),
      .threshold(db_threshold),
      .dout     (filt_out[gi]),
      .rise     (rise_nxt[gi]),
      .fall     (fall_nxt[gi])
    );
  end

  // A new edge overrides a clear strobe landing in the same cycle.
  always_comb begin
    edge_rise_d = rise_nxt;
    edge_fall_d = fall_nxt;
    pending_d   = (pending_q & ~clr) | (rise_nxt & rise_en) | (fall_nxt & fall_en);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      edge_rise_q <= '0;
      edge_fall_q <= '0;
      pending_q   <= '0;
    end else begin
      edge_rise_q <= edge_rise_d;
      edge_fall_q <= edge_fall_d;
      pending_q   <= pending_d;
    end
  end

  assign edge_rise = edge_rise_q;
  assign edge_fall = edge_fall_q;
  assign pending   = pending_q;
  assign irq       = |(pending_q & ie);

endmodule

// File: tb/tb_peripheral_gpio_edge_irq_bb.sv
// Bench for peripheral_gpio_edge_irq_bb: directed vector table, a same-cycle ie
// check, and a randomized phase against a reference model.
module tb_peripheral_gpio_edge_irq_bb;
  import peripheral_gpio_bb_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  gpio_vec_t  sync_in = '0;
  logic [3:0] db_threshold = '0;
  gpio_vec_t  rise_en = '0, fall_en = '0, ie = '0, clr = '0;
  gpio_vec_t  filt_out, edge_rise, edge_fall, pending;
  logic       irq;

  always #5 clk = ~clk;

  peripheral_gpio_edge_irq_bb #(.WIDTH(8), .DEBOUNCE_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .sync_in     (sync_in),
    .db_threshold(db_threshold),
    .rise_en     (rise_en),
    .fall_en     (fall_en),
    .ie          (ie),
    .clr         (clr),
    .filt_out    (filt_out),
    .edge_rise   (edge_rise),
    .edge_fall   (edge_fall),
    .pending     (pending),
    .irq         (irq)
  );

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic       rst;
    gpio_vec_t  sync_in;
    logic [3:0] thr;
    gpio_vec_t  rise_en, fall_en, ie, clr;
    gpio_vec_t  e_filt, e_rise, e_fall, e_pend;
    logic       e_irq;
  } vec_t;

  vec_t        tbl[$];
  logic [32:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          vec_idx  = 0;

  // reference model state for the random phase
  gpio_vec_t   m_filt = '0, m_pend = '0;
  logic [3:0]  m_cnt[8];

  function automatic vec_t mk(input logic r, input gpio_vec_t s, input logic [3:0] t,
                              input gpio_vec_t re, input gpio_vec_t fe, input gpio_vec_t ien,
                              input gpio_vec_t c, input gpio_vec_t ef, input gpio_vec_t er,
                              input gpio_vec_t efa, input gpio_vec_t ep, input logic ei);
    vec_t v;
    v.rst = r; v.sync_in = s; v.thr = t; v.rise_en = re; v.fall_en = fe; v.ie = ien;
    v.clr = c; v.e_filt = ef; v.e_rise = er; v.e_fall = efa; v.e_pend = ep; v.e_irq = ei;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d actual=%h expected=%h", name, vec_idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    logic [32:0] e;
    rst = v.rst; sync_in = v.sync_in; db_threshold = v.thr;
    rise_en = v.rise_en; fall_en = v.fall_en; ie = v.ie; clr = v.clr;
    exp_q.push_back({v.e_filt, v.e_rise, v.e_fall, v.e_pend, v.e_irq});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("filt_out",  filt_out,  e[32:25]);
    check("edge_rise", edge_rise, e[24:17]);
    check("edge_fall", edge_fall, e[16:9]);
    check("pending",   pending,   e[8:1]);
    check("irq",       {7'b0, irq}, {7'b0, e[0]});
    vec_idx++;
  endtask

  // Behavioural reference: fills the expected fields of v and advances the model.
  task automatic model_step(inout vec_t v);
    gpio_vec_t r, f;
    r = '0; f = '0;
    if (!v.rst) begin
      m_filt = '0; m_pend = '0;
      for (int i = 0; i < 8; i++) m_cnt[i] = '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (v.sync_in[i] == m_filt[i]) m_cnt[i] = '0;
        else if (m_cnt[i] >= v.thr) begin
          m_filt[i] = v.sync_in[i];
          m_cnt[i]  = '0;
          if (v.sync_in[i]) r[i] = 1'b1; else f[i] = 1'b1;
        end else m_cnt[i] = m_cnt[i] + 4'd1;
      end
      m_pend = (m_pend & ~v.clr) | (r & v.rise_en) | (f & v.fall_en);
    end
    v.e_filt = m_filt; v.e_rise = r; v.e_fall = f; v.e_pend = m_pend;
    v.e_irq = |(m_pend & v.ie);
  endtask

  // ---------------- test ----------------
  initial begin : main
    vec_t v;
    gpio_vec_t s;
    logic [31:0] r;

    // reset held 5 cycles with inputs high, then the power-on rise after 4 cycles
    repeat (5) tbl.push_back(mk(0, 8'hFF, 3, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    repeat (3) tbl.push_back(mk(1, 8'hFF, 3, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 8'hFF, 3, 0, 0, 0, 0, 8'hFF, 8'hFF, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 8'hFF, 3, 0, 0, 0, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 0));
    // zero threshold: one-cycle latency, rise sets pending and irq
    tbl.push_back(mk(1, 8'hFE, 0, 0,     0, 0,     0, 8'hFE, 8'h00, 8'h01, 8'h00, 0));
    tbl.push_back(mk(1, 8'hFF, 0, 8'h01, 0, 8'h01, 0, 8'hFF, 8'h01, 8'h00, 8'h01, 1));
    tbl.push_back(mk(1, 8'hFF, 0, 8'h01, 0, 8'h01, 0, 8'hFF, 8'h00, 8'h00, 8'h01, 1));
    tbl.push_back(mk(1, 8'hFB, 0, 0, 0, 8'h01, 0,     8'hFB, 8'h00, 8'h04, 8'h01, 1));
    tbl.push_back(mk(1, 8'hFB, 0, 0, 0, 8'h01, 8'h01, 8'hFB, 8'h00, 8'h00, 8'h00, 0));
    // threshold 5: 3-cycle glitch rejected, 6-cycle level accepted on cycle 6
    repeat (3) tbl.push_back(mk(1, 8'hFF, 5, 8'h04, 0, 8'h04, 0, 8'hFB, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'hFB, 5, 8'h04, 0, 8'h04, 0, 8'hFB, 0, 0, 0, 0));
    repeat (5) tbl.push_back(mk(1, 8'hFF, 5, 8'h04, 0, 8'h04, 0, 8'hFB, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'hFF, 5, 8'h04, 0, 8'h04, 0, 8'hFF, 8'h04, 8'h00, 8'h04, 1));
    tbl.push_back(mk(1, 8'hFF, 5, 8'h04, 0, 8'h04, 0, 8'hFF, 8'h00, 8'h00, 8'h04, 1));
    // W1C on pin 1, then set colliding with clear
    tbl.push_back(mk(1, 8'hFD, 0, 0, 8'h02, 8'h02, 8'h04, 8'hFD, 8'h00, 8'h02, 8'h02, 1));
    tbl.push_back(mk(1, 8'hFD, 0, 0, 8'h02, 8'h02, 8'h02, 8'hFD, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 8'hFF, 0, 0, 8'h02, 8'h02, 0,     8'hFF, 8'h02, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 8'hFD, 0, 0, 8'h02, 8'h02, 8'h02, 8'hFD, 8'h00, 8'h02, 8'h02, 1));
    tbl.push_back(mk(1, 8'hFD, 0, 0, 8'h02, 8'h02, 8'h01, 8'hFD, 8'h00, 8'h00, 8'h02, 1));
    // fall-only enable on pin 4; enables changing never clear pending
    tbl.push_back(mk(1, 8'hFD, 0, 0, 0, 0, 8'h02, 8'hFD, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 8'hED, 0, 0, 0,     0, 0, 8'hED, 8'h00, 8'h10, 8'h00, 0));
    tbl.push_back(mk(1, 8'hFD, 0, 0, 8'h10, 0, 0, 8'hFD, 8'h10, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 8'hED, 0, 0, 8'h10, 0, 0, 8'hED, 8'h00, 8'h10, 8'h10, 0));
    tbl.push_back(mk(1, 8'hED, 0, 8'hFF, 0, 0, 0, 8'hED, 8'h00, 8'h00, 8'h10, 0));

    foreach (tbl[k]) apply(tbl[k]);

    // enabling ie on a pending bit raises irq without waiting for a clock edge
    ie = 8'h10;
    #1;
    check("irq_same_cycle_ie", {7'b0, irq}, 8'h01);
    ie = 8'h00;
    #1;
    check("irq_ie_off", {7'b0, irq}, 8'h00);
    tbl.delete();

    // lowering the threshold mid-count commits on the next cycle
    repeat (3) tbl.push_back(mk(1, 8'hEC, 7, 0, 8'h01, 0, 0, 8'hED, 0, 0, 8'h10, 0));
    tbl.push_back(mk(1, 8'hEC, 1, 0, 8'h01, 0, 0, 8'hEC, 8'h00, 8'h01, 8'h11, 0));
    // reset mid-count clears everything
    repeat (2) tbl.push_back(mk(1, 8'hFC, 3, 0, 0, 0, 0, 8'hEC, 0, 0, 8'h11, 0));
    tbl.push_back(mk(0, 8'hFC, 3, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 8'h00, 3, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0));
    foreach (tbl[k]) apply(tbl[k]);

    // random phase: model starts from the all-zero state the last vectors left
    m_filt = '0; m_pend = '0;
    for (int i = 0; i < 8; i++) m_cnt[i] = '0;
    s = '0;
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      s = s ^ (r[7:0] & r[15:8] & r[23:16]);
      v = mk(($urandom_range(0, 99) != 0), s, 4'($urandom_range(0, 3)),
             8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom & $urandom),
             0, 0, 0, 0, 0);
      model_step(v);
      apply(v);
    end

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
